// File: rtl/dice_cgra_cfg_loader_if.sv
// Configuration word stream between the config-fetch logic (master) and the
// CGRA configuration loader (slave), using a valid/ready handshake.
interface dice_cgra_cfg_loader_if #(
  parameter int WORD_W = 32
);
  logic              cfg_word_valid;
  logic [WORD_W-1:0] cfg_word;
  logic              cfg_word_ready;

  modport master (
    output cfg_word_valid,
    output cfg_word,
    input  cfg_word_ready
  );

  modport slave (
    input  cfg_word_valid,
    input  cfg_word,
    output cfg_word_ready
  );
endinterface

// File: rtl/dice_cgra_cfg_loader.sv
// Packs a stream of configuration words into a per-tile staging buffer and
// commits it atomically to the flat CGRA configuration bus once every tile is loaded.
module dice_cgra_cfg_loader #(
  parameter int NUM_TILES  = 16,
  parameter int TILE_CFG_W = 156,
  parameter int WORD_W     = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  dice_cgra_cfg_loader_if.slave            bus,
  output logic                             busy,
  output logic                             done,
  output logic [4:0]                       tiles_loaded,
  output logic [TILE_CFG_W*NUM_TILES-1:0]  cgra_cfg
);

  localparam int WORDS_PER_TILE = (TILE_CFG_W + WORD_W - 1) / WORD_W;
  localparam int LAST_W         = TILE_CFG_W - (WORDS_PER_TILE - 1) * WORD_W;
  localparam int CFG_W          = TILE_CFG_W * NUM_TILES;
  localparam int OFF_W          = $clog2(CFG_W);
  localparam int WCNT_W         = $clog2(WORDS_PER_TILE);
  localparam int TIDX_W         = $clog2(NUM_TILES);

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_TILE - 1);
  localparam logic [4:0]        LAST_TILE = 5'(NUM_TILES - 1);
  localparam logic [OFF_W-1:0]  LAST_OFF  = OFF_W'((WORDS_PER_TILE - 1) * WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [WCNT_W-1:0]  word_cnt_r;
  logic [4:0]         tiles_loaded_r;
  logic [CFG_W-1:0]   staging_r;
  logic [CFG_W-1:0]   cgra_cfg_r;
  logic               done_r;
  logic               busy_r;
  logic               ready_s;
  logic               hs_s;
  logic               last_word_s;
  logic [TIDX_W-1:0]  tile_idx_s;
  logic [OFF_W-1:0]   tile_base_s;
  logic [OFF_W-1:0]   word_off_s;

  // abort forces ready low so a word presented alongside it is never consumed
  assign ready_s            = (state_r == ST_LOAD) && !abort;
  assign bus.cfg_word_ready = ready_s;
  assign hs_s               = bus.cfg_word_valid && ready_s;
  assign last_word_s        = (word_cnt_r == LAST_WORD);
  assign tile_idx_s         = tiles_loaded_r[TIDX_W-1:0];
  assign tile_base_s        = OFF_W'(tile_idx_s) * OFF_W'(TILE_CFG_W);
  assign word_off_s         = OFF_W'(word_cnt_r) * OFF_W'(WORD_W);

  assign busy         = busy_r;
  assign done         = done_r;
  assign tiles_loaded = tiles_loaded_r;
  assign cgra_cfg     = cgra_cfg_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_LOAD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          next_state_s = ST_IDLE;
        end else if (hs_s && last_word_s && (tiles_loaded_r == LAST_TILE)) begin
          next_state_s = ST_COMMIT;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_COMMIT: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Word and tile position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_r     <= '0;
      tiles_loaded_r <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            word_cnt_r     <= '0;
            tiles_loaded_r <= 5'd0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            word_cnt_r     <= '0;
            tiles_loaded_r <= 5'd0;
          end else if (hs_s) begin
            if (last_word_s) begin
              word_cnt_r     <= '0;
              tiles_loaded_r <= tiles_loaded_r + 5'd1;
            end else begin
              word_cnt_r <= word_cnt_r + WCNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Staging buffer; the final word of a tile only carries the tile's top LAST_W bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_r <= '0;
    end else if (hs_s) begin
      if (last_word_s) begin
        staging_r[tile_base_s + LAST_OFF +: LAST_W] <= bus.cfg_word[LAST_W-1:0];
      end else begin
        staging_r[tile_base_s + word_off_s +: WORD_W] <= bus.cfg_word;
      end
    end
  end

  // Registered outputs: atomic commit, done pulse and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cgra_cfg_r <= '0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      if (state_r == ST_COMMIT) begin
        cgra_cfg_r <= staging_r;
      end
      done_r <= (state_r == ST_COMMIT);
      busy_r <= (next_state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_dice_cgra_cfg_loader.sv
// Scoreboard bench for dice_cgra_cfg_loader: loads push the expected committed image,
// a monitor pops it on every done pulse and otherwise requires cgra_cfg to hold.
module tb_dice_cgra_cfg_loader;

  localparam int NT = 16;
  localparam int TW = 156;
  localparam int WW = 32;
  localparam int NW = 80;
  localparam int CW = NT * TW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [4:0]    tiles_loaded;
  logic [CW-1:0] cgra_cfg;

  dice_cgra_cfg_loader_if #(.WORD_W(WW)) bus ();

  dice_cgra_cfg_loader #(
    .NUM_TILES  (NT),
    .TILE_CFG_W (TW),
    .WORD_W     (WW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .bus          (bus.slave),
    .busy         (busy),
    .done         (done),
    .tiles_loaded (tiles_loaded),
    .cgra_cfg     (cgra_cfg)
  );

  always #5 clk = ~clk;

  int            chk_cnt = 0;
  int            err_cnt = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] cur_img = '0;
  logic [CW-1:0] ramp_img;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_img(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      for (int t = 0; t < NT; t++) begin
        if (act[t*TW +: TW] !== exp[t*TW +: TW]) begin
          $display("FAIL %s: tile %0d got %h expected %h", nm, t, act[t*TW +: TW], exp[t*TW +: TW]);
          break;
        end
      end
    end
  endtask

  function automatic logic [31:0] word_of(input int n, input bit ones);
    return ones ? 32'hFFFF_FFFF : 32'h1000_0000 + 32'(n);
  endfunction

  // Hand-packed ramp image: tile k holds words 5k..5k+4, top nibble of word 4 dropped
  function automatic logic [CW-1:0] build_ramp();
    logic [CW-1:0] img = '0;
    logic [31:0]   w;
    for (int n = 0; n < NW; n++) begin
      w = word_of(n, 1'b0);
      if ((n % 5) == 4) img[(n/5)*TW + 128 +: 28] = w[27:0];
      else              img[(n/5)*TW + (n%5)*32 +: 32] = w;
    end
    return img;
  endfunction

  // Monitor: pop on done, otherwise the committed image must not move
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_img = '0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 64'(done), 64'd0);
        end else begin
          cur_img = exp_q.pop_front();
          chk_img("commit_img", cgra_cfg, cur_img);
        end
      end else begin
        chk_img("cfg_hold", cgra_cfg, cur_img);
      end
    end
  end

  task automatic do_load(input bit ones, input bit bubbly, input int abort_at,
                         input bit start_mid, input bit start_commit,
                         input logic [CW-1:0] prev_img);
    int n   = 0;
    int cyc = 0;
    bit hs;
    if (abort_at < 0) exp_q.push_back(ones ? {CW{1'b1}} : ramp_img);
    @(negedge clk);
    start = 1'b1;
    #1 chk("ready_idle", 64'(bus.cfg_word_ready), 64'd0);
    @(negedge clk);
    start = 1'b0;
    #1 chk("busy_load", 64'(busy), 64'd1);
    while (n < NW && cyc < 2000) begin
      bus.cfg_word_valid = bubbly ? (((cyc % 4) != 1) && ((cyc % 7) != 3)) : 1'b1;
      bus.cfg_word       = word_of(n, ones);
      start              = start_mid && (n == 20);
      abort              = (n == abort_at);
      #1;
      if (abort) begin
        chk("ready_abort", 64'(bus.cfg_word_ready), 64'd0);
        @(negedge clk);
        abort = 1'b0;
        bus.cfg_word_valid = 1'b0;
        #1;
        chk("busy_abort", 64'(busy), 64'd0);
        chk("tiles_abort", 64'(tiles_loaded), 64'd0);
        chk_img("abort_hold", cgra_cfg, prev_img);
        repeat (3) @(negedge clk);
        chk("done_abort", 64'(done), 64'd0);
        return;
      end
      chk("ready_load", 64'(bus.cfg_word_ready), 64'd1);
      hs = bus.cfg_word_valid && bus.cfg_word_ready;
      @(negedge clk);
      if (hs) n++;
      cyc++;
    end
    chk("load_timeout", 64'(n), 64'(NW));
    bus.cfg_word_valid = 1'b0;
    start = start_commit;
    #1;
    chk("done_early", 64'(done), 64'd0);
    chk("busy_commit", 64'(busy), 64'd1);
    chk("ready_commit", 64'(bus.cfg_word_ready), 64'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("tiles_16", 64'(tiles_loaded), 64'd16);
    @(negedge clk);
    #1;
    chk("done_once", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    bus.cfg_word_valid = 1'b0;
    bus.cfg_word       = '0;
    ramp_img           = build_ramp();

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(bus.cfg_word_ready), 64'd0);
    chk("rst_tiles", 64'(tiles_loaded), 64'd0);
    chk_img("rst_cfg", cgra_cfg, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Full ramp load, valid held high, with a stray start mid-load
    do_load(1'b0, 1'b0, -1, 1'b1, 1'b0, '0);
    chk("t0_w0", 64'(cgra_cfg[31:0]), 64'h1000_0000);
    chk("t0_top", 64'(cgra_cfg[155:128]), 64'h000_0004);
    chk("t15_top", 64'(cgra_cfg[15*TW+128 +: 28]), 64'h000_004F);

    // Same data with valid bubbles, stray start during COMMIT
    do_load(1'b0, 1'b1, -1, 1'b0, 1'b1, ramp_img);

    // Abort after 42 words with valid still asserted
    do_load(1'b1, 1'b0, 42, 1'b0, 1'b0, ramp_img);

    // All-ones load; monitor sees ramp until the single flip cycle
    do_load(1'b1, 1'b0, -1, 1'b0, 1'b0, ramp_img);
    chk_img("ones_img", cgra_cfg, {CW{1'b1}});

    // Asynchronous reset after 7 words of a new load
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.cfg_word_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.cfg_word = word_of(i, 1'b0);
      @(negedge clk);
    end
    bus.cfg_word_valid = 1'b0;
    chk("tiles_pre_rst", 64'(tiles_loaded), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_img("rst_mid_cfg", cgra_cfg, '0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_ready", 64'(bus.cfg_word_ready), 64'd0);
    chk("rst_mid_tiles", 64'(tiles_loaded), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
